// File: rtl/ex_mem_if.sv
// ex_mem_if: bundle of everything that crosses the ex/mem pipeline register
// apart from clock and reset.
//   control   : stall[5:0] (1 = stop, [0]=pc .. [5]=wb), flush
//   ex side   : ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
//               hilo_i / cnt_i (madd/msub partial product and step count)
//   mem side  : mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo
//   feedback  : hilo_o / cnt_o back to ex, bubble_cnt perf counter
// Modports: master = pipeline control + ex stage (drives inputs),
//           slave  = the ex_mem register itself.
interface ex_mem_if #(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
);
  logic [5:0]        stall;
  logic              flush;
  logic [4:0]        ex_wd;
  logic              ex_wreg;
  logic [31:0]       ex_wdata;
  logic [31:0]       ex_hi;
  logic [31:0]       ex_lo;
  logic              ex_whilo;
  logic [63:0]       hilo_i;
  logic [CNT_W-1:0]  cnt_i;
  logic [4:0]        mem_wd;
  logic              mem_wreg;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_hi;
  logic [31:0]       mem_lo;
  logic              mem_whilo;
  logic [63:0]       hilo_o;
  logic [CNT_W-1:0]  cnt_o;
  logic [PERF_W-1:0] bubble_cnt;

  modport master (
    output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
           hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
           hilo_o, cnt_o, bubble_cnt
  );

  modport slave (
    input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
           hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
           hilo_o, cnt_o, bubble_cnt
  );
endinterface

// File: rtl/ex_mem.sv
// ex_mem: pipeline register between execute and memory access.
// Carries GPR and HI/LO write-back results from ex to mem with one cycle of
// latency, applies stall/flush (inserting NOP bubbles), holds the two-cycle
// madd/msub partial product and step count for ex to read back, and keeps a
// saturating count of inserted bubbles.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : ex_mem_if.slave (stall/flush, ex_* in, mem_*/hilo_o/cnt_o/bubble_cnt out)
module ex_mem #(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_mem_if.slave     bus
);

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  logic [4:0]        mem_wd_reg;
  logic              mem_wreg_reg;
  logic [31:0]       mem_wdata_reg;
  logic [31:0]       mem_hi_reg;
  logic [31:0]       mem_lo_reg;
  logic              mem_whilo_reg;
  logic [63:0]       hilo_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [PERF_W-1:0] bubble_reg;
  logic [PERF_W-1:0] bubble_next;

  // Stage 3 (ex) stopped while stage 4 (mem) keeps going: mem must see a NOP.
  logic ex_stall_mem_free;
  // stall[3]=0 with stall[4]=1 never comes from ctrl; it falls into the
  // pass-through branch along with the normal stall[3]=0 case.
  logic ex_running;

  assign ex_stall_mem_free = bus.stall[3] & ~bus.stall[4];
  assign ex_running        = ~bus.stall[3];

  // Saturating increment: stop at all-ones rather than wrapping.
  always_comb begin
    bubble_next = bubble_reg;
    if (bubble_reg != {PERF_W{1'b1}})
      bubble_next = bubble_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wd_reg    <= NOP_REG_ADDR;
      mem_wreg_reg  <= 1'b0;
      mem_wdata_reg <= 32'd0;
      mem_hi_reg    <= 32'd0;
      mem_lo_reg    <= 32'd0;
      mem_whilo_reg <= 1'b0;
      hilo_reg      <= 64'd0;
      cnt_reg       <= '0;
      bubble_reg    <= '0;
    end else if (bus.flush) begin
      // A flushed slot is not a stall bubble, so the counter is left alone;
      // any half-finished madd/msub is abandoned.
      mem_wd_reg    <= NOP_REG_ADDR;
      mem_wreg_reg  <= 1'b0;
      mem_wdata_reg <= 32'd0;
      mem_hi_reg    <= 32'd0;
      mem_lo_reg    <= 32'd0;
      mem_whilo_reg <= 1'b0;
      hilo_reg      <= 64'd0;
      cnt_reg       <= '0;
    end else if (ex_stall_mem_free) begin
      // Bubble into mem, but keep ex's first-cycle madd/msub result so the
      // second cycle can pick it up from hilo_o/cnt_o.
      mem_wd_reg    <= NOP_REG_ADDR;
      mem_wreg_reg  <= 1'b0;
      mem_wdata_reg <= 32'd0;
      mem_hi_reg    <= 32'd0;
      mem_lo_reg    <= 32'd0;
      mem_whilo_reg <= 1'b0;
      hilo_reg      <= bus.hilo_i;
      cnt_reg       <= bus.cnt_i;
      bubble_reg    <= bubble_next;
    end else if (ex_running) begin
      mem_wd_reg    <= bus.ex_wd;
      mem_wreg_reg  <= bus.ex_wreg;
      mem_wdata_reg <= bus.ex_wdata;
      mem_hi_reg    <= bus.ex_hi;
      mem_lo_reg    <= bus.ex_lo;
      mem_whilo_reg <= bus.ex_whilo;
      hilo_reg      <= 64'd0;
      cnt_reg       <= '0;
    end
    // Remaining case (ex and mem both stalled): every register holds.
  end

  assign bus.mem_wd     = mem_wd_reg;
  assign bus.mem_wreg   = mem_wreg_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.mem_hi     = mem_hi_reg;
  assign bus.mem_lo     = mem_lo_reg;
  assign bus.mem_whilo  = mem_whilo_reg;
  assign bus.hilo_o     = hilo_reg;
  assign bus.cnt_o      = cnt_reg;
  assign bus.bubble_cnt = bubble_reg;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed self-checking bench for ex_mem.
// A full-size instance (PERF_W=32) carries the functional tests; a second
// instance with PERF_W=4 shares the same stimulus and is used to observe
// bubble counter saturation.
module tb_ex_mem;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cycle;

  ex_mem_if #(.CNT_W(2), .PERF_W(32)) bus ();
  ex_mem_if #(.CNT_W(2), .PERF_W(4))  bus_s ();

  ex_mem #(.CNT_W(2), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  ex_mem #(.CNT_W(2), .PERF_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  assign bus_s.stall    = bus.stall;
  assign bus_s.flush    = bus.flush;
  assign bus_s.ex_wd    = bus.ex_wd;
  assign bus_s.ex_wreg  = bus.ex_wreg;
  assign bus_s.ex_wdata = bus.ex_wdata;
  assign bus_s.ex_hi    = bus.ex_hi;
  assign bus_s.ex_lo    = bus.ex_lo;
  assign bus_s.ex_whilo = bus.ex_whilo;
  assign bus_s.hilo_i   = bus.hilo_i;
  assign bus_s.cnt_i    = bus.cnt_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl never produces "ex running while mem stalled".
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(!bus.stall[3] && bus.stall[4]))
      else begin
        $display("FAIL illegal_stall: stall=%b required stall[3]=1 whenever stall[4]=1", bus.stall);
        errors++;
      end
    end
  end

  // Advance one clock; outputs are sampled 1 ns after the edge and inputs
  // changed afterwards, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    $display("cyc %0d rst=%0b flush=%0b stall=%b -> wd=%0d wreg=%0b wdata=%h hi=%h lo=%h whilo=%0b hilo_o=%h cnt_o=%0d bub=%0d bub4=%0d",
             cycle, rst, bus.flush, bus.stall, bus.mem_wd, bus.mem_wreg, bus.mem_wdata,
             bus.mem_hi, bus.mem_lo, bus.mem_whilo, bus.hilo_o, bus.cnt_o,
             bus.bubble_cnt, bus_s.bubble_cnt);
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    bus.ex_wd    = wd;
    bus.ex_wreg  = wreg;
    bus.ex_wdata = wdata;
    bus.ex_hi    = hi;
    bus.ex_lo    = lo;
    bus.ex_whilo = whilo;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.stall = 6'b0;
    bus.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_ex(5'($urandom), 1'b1, $urandom, $urandom, $urandom, 1'b1);
      bus.hilo_i = {$urandom, $urandom};
      bus.cnt_i  = 2'($urandom);
      step();
    end
    checks += 10;
    if (bus.mem_wd !== 5'd0)     begin errors++; $display("FAIL reset_wd: got %0d want 0", bus.mem_wd); end
    if (bus.mem_wreg !== 1'b0)   begin errors++; $display("FAIL reset_wreg: got %0b want 0", bus.mem_wreg); end
    if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    if (bus.mem_hi !== 32'd0)    begin errors++; $display("FAIL reset_hi: got %h want 0", bus.mem_hi); end
    if (bus.mem_lo !== 32'd0)    begin errors++; $display("FAIL reset_lo: got %h want 0", bus.mem_lo); end
    if (bus.mem_whilo !== 1'b0)  begin errors++; $display("FAIL reset_whilo: got %0b want 0", bus.mem_whilo); end
    if (bus.hilo_o !== 64'd0)    begin errors++; $display("FAIL reset_hilo: got %h want 0", bus.hilo_o); end
    if (bus.cnt_o !== 2'd0)      begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt_o); end
    if (bus.bubble_cnt !== 32'd0) begin errors++; $display("FAIL reset_bubble: got %0d want 0", bus.bubble_cnt); end
    if (bus_s.bubble_cnt !== 4'd0) begin errors++; $display("FAIL reset_bubble4: got %0d want 0", bus_s.bubble_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    bus.stall = 6'b0;
    set_ex(5'd3, 1'b1, 32'h1234_5678, 32'hA, 32'hB, 1'b1);
    bus.hilo_i = 64'h5555_5555_5555_5555;
    bus.cnt_i  = 2'd2;
    step();
    checks += 8;
    if (bus.mem_wd !== 5'd3)            begin errors++; $display("FAIL pass_wd: got %0d want 3", bus.mem_wd); end
    if (bus.mem_wreg !== 1'b1)          begin errors++; $display("FAIL pass_wreg: got %0b want 1", bus.mem_wreg); end
    if (bus.mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL pass_wdata: got %h want 12345678", bus.mem_wdata); end
    if (bus.mem_hi !== 32'hA)           begin errors++; $display("FAIL pass_hi: got %h want a", bus.mem_hi); end
    if (bus.mem_lo !== 32'hB)           begin errors++; $display("FAIL pass_lo: got %h want b", bus.mem_lo); end
    if (bus.mem_whilo !== 1'b1)         begin errors++; $display("FAIL pass_whilo: got %0b want 1", bus.mem_whilo); end
    if (bus.cnt_o !== 2'd0)             begin errors++; $display("FAIL pass_cnt: got %0d want 0", bus.cnt_o); end
    if (bus.hilo_o !== 64'd0)           begin errors++; $display("FAIL pass_hilo: got %h want 0", bus.hilo_o); end
  endtask

  task automatic test_madd();
    // First cycle: ex stalled, mem free -> bubble, partial product captured.
    bus.stall  = 6'b001111;
    set_ex(5'd7, 1'b1, 32'hDEAD_0007, 32'h77, 32'h78, 1'b1);
    bus.hilo_i = 64'hFFFF_FFFF_0000_0001;
    bus.cnt_i  = 2'd1;
    step();
    checks += 7;
    if (bus.mem_wreg !== 1'b0)  begin errors++; $display("FAIL madd1_wreg: got %0b want 0", bus.mem_wreg); end
    if (bus.mem_whilo !== 1'b0) begin errors++; $display("FAIL madd1_whilo: got %0b want 0", bus.mem_whilo); end
    if (bus.mem_wd !== 5'd0)    begin errors++; $display("FAIL madd1_wd: got %0d want 0", bus.mem_wd); end
    if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL madd1_wdata: got %h want 0", bus.mem_wdata); end
    if (bus.hilo_o !== 64'hFFFF_FFFF_0000_0001) begin errors++; $display("FAIL madd1_hilo: got %h want ffffffff00000001", bus.hilo_o); end
    if (bus.cnt_o !== 2'd1)     begin errors++; $display("FAIL madd1_cnt: got %0d want 1", bus.cnt_o); end
    if (bus.bubble_cnt !== 32'd1) begin errors++; $display("FAIL madd1_bubble: got %0d want 1", bus.bubble_cnt); end
    // Second cycle: ex completes and passes its result.
    bus.stall = 6'b0;
    set_ex(5'd9, 1'b1, 32'hCAFE_0001, 32'h11, 32'h22, 1'b0);
    bus.hilo_i = 64'h0;
    bus.cnt_i  = 2'd2;
    step();
    checks += 6;
    if (bus.mem_wd !== 5'd9)            begin errors++; $display("FAIL madd2_wd: got %0d want 9", bus.mem_wd); end
    if (bus.mem_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL madd2_wdata: got %h want cafe0001", bus.mem_wdata); end
    if (bus.mem_whilo !== 1'b0)         begin errors++; $display("FAIL madd2_whilo: got %0b want 0", bus.mem_whilo); end
    if (bus.cnt_o !== 2'd0)             begin errors++; $display("FAIL madd2_cnt: got %0d want 0", bus.cnt_o); end
    if (bus.hilo_o !== 64'd0)           begin errors++; $display("FAIL madd2_hilo: got %h want 0", bus.hilo_o); end
    if (bus.bubble_cnt !== 32'd1)       begin errors++; $display("FAIL madd2_bubble: got %0d want 1", bus.bubble_cnt); end
  endtask

  task automatic test_hold();
    // ex and mem both stalled after the valid transfer {9,1,cafe0001,11,22,0}.
    bus.stall = 6'b011111;
    set_ex(5'd30, 1'b0, 32'hFFFF_0000, 32'h99, 32'h98, 1'b1);
    bus.hilo_i = 64'h1234;
    bus.cnt_i  = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 7;
      if (bus.mem_wd !== 5'd9)            begin errors++; $display("FAIL hold_wd[%0d]: got %0d want 9", i, bus.mem_wd); end
      if (bus.mem_wreg !== 1'b1)          begin errors++; $display("FAIL hold_wreg[%0d]: got %0b want 1", i, bus.mem_wreg); end
      if (bus.mem_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL hold_wdata[%0d]: got %h want cafe0001", i, bus.mem_wdata); end
      if (bus.mem_lo !== 32'h22)          begin errors++; $display("FAIL hold_lo[%0d]: got %h want 22", i, bus.mem_lo); end
      if (bus.hilo_o !== 64'd0)           begin errors++; $display("FAIL hold_hilo[%0d]: got %h want 0", i, bus.hilo_o); end
      if (bus.cnt_o !== 2'd0)             begin errors++; $display("FAIL hold_cnt[%0d]: got %0d want 0", i, bus.cnt_o); end
      if (bus.bubble_cnt !== 32'd1)       begin errors++; $display("FAIL hold_bubble[%0d]: got %0d want 1", i, bus.bubble_cnt); end
    end
    // Capture a partial product, then hold it through a full stall.
    bus.stall  = 6'b001111;
    bus.hilo_i = 64'hDEAD_BEEF_0000_0002;
    bus.cnt_i  = 2'd1;
    step();
    bus.stall  = 6'b011111;
    bus.hilo_i = 64'h0BAD_0BAD_0BAD_0BAD;
    bus.cnt_i  = 2'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks += 3;
      if (bus.hilo_o !== 64'hDEAD_BEEF_0000_0002) begin errors++; $display("FAIL hold2_hilo[%0d]: got %h want deadbeef00000002", i, bus.hilo_o); end
      if (bus.cnt_o !== 2'd1)       begin errors++; $display("FAIL hold2_cnt[%0d]: got %0d want 1", i, bus.cnt_o); end
      if (bus.bubble_cnt !== 32'd2) begin errors++; $display("FAIL hold2_bubble[%0d]: got %0d want 2", i, bus.bubble_cnt); end
    end
  endtask

  task automatic test_flush();
    // hilo_o/cnt_o currently hold deadbeef00000002 / 1.
    bus.flush  = 1'b1;
    bus.stall  = 6'b001111;
    set_ex(5'd5, 1'b1, 32'h5555_AAAA, 32'h1, 32'h2, 1'b1);
    bus.hilo_i = 64'h7777_7777_7777_7777;
    bus.cnt_i  = 2'd1;
    step();
    checks += 8;
    if (bus.mem_wd !== 5'd0)      begin errors++; $display("FAIL flush_wd: got %0d want 0", bus.mem_wd); end
    if (bus.mem_wreg !== 1'b0)    begin errors++; $display("FAIL flush_wreg: got %0b want 0", bus.mem_wreg); end
    if (bus.mem_wdata !== 32'd0)  begin errors++; $display("FAIL flush_wdata: got %h want 0", bus.mem_wdata); end
    if (bus.mem_hi !== 32'd0)     begin errors++; $display("FAIL flush_hi: got %h want 0", bus.mem_hi); end
    if (bus.mem_whilo !== 1'b0)   begin errors++; $display("FAIL flush_whilo: got %0b want 0", bus.mem_whilo); end
    if (bus.hilo_o !== 64'd0)     begin errors++; $display("FAIL flush_hilo: got %h want 0", bus.hilo_o); end
    if (bus.cnt_o !== 2'd0)       begin errors++; $display("FAIL flush_cnt: got %0d want 0", bus.cnt_o); end
    if (bus.bubble_cnt !== 32'd2) begin errors++; $display("FAIL flush_bubble: got %0d want 2", bus.bubble_cnt); end
    // Flush also overrides a normal pass-through.
    bus.stall = 6'b0;
    step();
    checks += 3;
    if (bus.mem_wd !== 5'd0)      begin errors++; $display("FAIL flush2_wd: got %0d want 0", bus.mem_wd); end
    if (bus.mem_wreg !== 1'b0)    begin errors++; $display("FAIL flush2_wreg: got %0b want 0", bus.mem_wreg); end
    if (bus.bubble_cnt !== 32'd2) begin errors++; $display("FAIL flush2_bubble: got %0d want 2", bus.bubble_cnt); end
    bus.flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  wd_tab    [4] = '{5'd1, 5'd31, 5'd16, 5'd12};
    logic [31:0] wdata_tab [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0F0F_F0F0};
    logic [31:0] hi_tab    [4] = '{32'h1111_0000, 32'h0, 32'hFFFF_FFFF, 32'h2468_ACE0};
    logic [31:0] lo_tab    [4] = '{32'h0000_2222, 32'hFFFF_FFFF, 32'h0, 32'h1357_9BDF};
    bus.stall = 6'b0;
    for (int i = 0; i < 4; i++) begin
      set_ex(wd_tab[i], i[0], wdata_tab[i], hi_tab[i], lo_tab[i], ~i[0]);
      step();
      checks += 6;
      if (bus.mem_wd !== wd_tab[i])       begin errors++; $display("FAIL b2b_wd[%0d]: got %0d want %0d", i, bus.mem_wd, wd_tab[i]); end
      if (bus.mem_wreg !== i[0])          begin errors++; $display("FAIL b2b_wreg[%0d]: got %0b want %0b", i, bus.mem_wreg, i[0]); end
      if (bus.mem_wdata !== wdata_tab[i]) begin errors++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, bus.mem_wdata, wdata_tab[i]); end
      if (bus.mem_hi !== hi_tab[i])       begin errors++; $display("FAIL b2b_hi[%0d]: got %h want %h", i, bus.mem_hi, hi_tab[i]); end
      if (bus.mem_lo !== lo_tab[i])       begin errors++; $display("FAIL b2b_lo[%0d]: got %h want %h", i, bus.mem_lo, lo_tab[i]); end
      if (bus.mem_whilo !== ~i[0])        begin errors++; $display("FAIL b2b_whilo[%0d]: got %0b want %0b", i, bus.mem_whilo, ~i[0]); end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] want4;
    rst       = 1'b1;
    bus.stall = 6'b0;
    step();
    rst       = 1'b0;
    bus.stall = 6'b001111;
    for (int i = 1; i <= 20; i++) begin
      step();
      want4 = (i >= 15) ? 4'hF : 4'(i);
      checks += 1;
      if (bus_s.bubble_cnt !== want4) begin errors++; $display("FAIL sat_bubble4[%0d]: got %0d want %0d", i, bus_s.bubble_cnt, want4); end
    end
    checks += 1;
    if (bus.bubble_cnt !== 32'd20) begin errors++; $display("FAIL sat_bubble32: got %0d want 20", bus.bubble_cnt); end
    bus.stall = 6'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    rst    = 1'b1;
    bus.stall  = 6'b0;
    bus.flush  = 1'b0;
    bus.hilo_i = 64'd0;
    bus.cnt_i  = 2'd0;
    set_ex(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_pass();
    test_madd();
    test_hold();
    test_flush();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
